// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, imem handshake, held instruction.
// Two-state FSM (FETCH/HOLD) with redirect flush and accept counter.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    FETCH,
    HOLD
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_n;
  logic [31:0] instr_pc_n;
  logic        instr_valid_n;
  logic [31:0] fetch_count_n;

  // Request depends on state only; reset masks it so memory sees no request.
  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;

  // Decode slices; instr is NOP whenever nothing is held.
  assign op     = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Next-state logic: redirect wins, then fetch capture or accept.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    fetch_count_n = fetch_count;
    if (redirect_valid) begin
      pc_n          = redirect_pc & ~32'h3;
      instr_n       = NOP_INSTR;
      instr_valid_n = 1'b0;
      state_n       = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            instr_n       = imem_rdata;
            instr_pc_n    = pc;
            pc_n          = pc + 32'd4;
            instr_valid_n = 1'b1;
            state_n       = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_n       = NOP_INSTR;
            instr_valid_n = 1'b0;
            fetch_count_n = fetch_count + 32'd1;
            state_n       = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      fetch_count <= fetch_count_n;
    end
  end

endmodule
